// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcodes,
// ALU operation codes and the per-state control word decode.
package uc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      DIR_MEM = 4'd3,
      LEE_MEM = 4'd4,
      ESC_MEM = 4'd5,
      WB_R    = 4'd6,
      WB_MEM  = 4'd7,
      SALTO   = 4'd8,
      ERROR   = 4'd9
   } estado_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       error;
   } ctrl_t;

   // Control word is a pure function of the state (Moore decode).
   function automatic ctrl_t decodifica(estado_t e);
      ctrl_t c;
      c = '0;
      case (e)
         FETCH: begin
            c.mem_req  = 1'b1;
            c.mem_read = 1'b1;
            c.ir_write = 1'b1;
            c.pc_write = 1'b1;
            c.alu_op   = ALU_ADD;
         end
         EXEC_R:  c.alu_op = ALU_FUNCT;
         DIR_MEM: c.alu_op = ALU_ADD;
         LEE_MEM: begin
            c.mem_req  = 1'b1;
            c.mem_read = 1'b1;
         end
         ESC_MEM: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
         end
         WB_R:    c.reg_write = 1'b1;
         WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         SALTO: begin
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
         end
         ERROR:   c.error = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/unidad_control_multiciclo_contador_espera.sv
// Memory wait counter: counts stalled cycles of one access and flags the
// cycle whose stall would reach the MAX_ESPERA limit.
module contador_espera #(
   parameter int unsigned MAX_ESPERA = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic limite
);

   localparam int unsigned W = $clog2(MAX_ESPERA + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != W'(MAX_ESPERA)))
         cnt_d = cnt_q + 1'b1;
   end

   // High during the stalled cycle whose increment reaches the limit.
   assign limite = enable && (cnt_q == W'(MAX_ESPERA - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle processor control unit (Moore FSM, registered outputs).
// Define UC_CONTADOR_INSTR_EN to build the retired-instruction counter.
module unidad_control_multiciclo
   import uc_pkg::*;
#(
   parameter int unsigned ANCHO_OP   = 6,
   parameter int unsigned MAX_ESPERA = 15,
   parameter int unsigned ANCHO_CONT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ANCHO_OP-1:0]   op,
   input  logic                  mem_listo,
   output logic                  mem_req,
   output logic                  MemRead,
   output logic                  MemToWrite,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  PCWriteCond,
   output logic                  RegWrite,
   output logic                  MemToReg,
   output logic [1:0]            AluOp,
   output logic [3:0]            estado,
   output logic                  op_invalida,
   output logic                  error,
   output logic [ANCHO_CONT-1:0] instr_cont
);

   localparam logic [ANCHO_OP-1:0] OPC_R   = ANCHO_OP'(OP_R);
   localparam logic [ANCHO_OP-1:0] OPC_LW  = ANCHO_OP'(OP_LW);
   localparam logic [ANCHO_OP-1:0] OPC_SW  = ANCHO_OP'(OP_SW);
   localparam logic [ANCHO_OP-1:0] OPC_BEQ = ANCHO_OP'(OP_BEQ);

   estado_t             state_q, state_d;
   logic [ANCHO_OP-1:0] op_reg_q, op_reg_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic                op_invalida_q, op_invalida_d;
   logic                limite, clr_espera, en_espera;

   // Stall counting is keyed off the registered mem_req, so no input reaches an output.
   assign en_espera  = ctrl_q.mem_req && !mem_listo;
   assign clr_espera = (state_d != state_q);

   contador_espera #(
      .MAX_ESPERA(MAX_ESPERA)
   ) u_espera (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clr_espera),
      .enable (en_espera),
      .limite (limite)
   );

   always_comb begin
      state_d  = state_q;
      op_reg_d = op_reg_q;
      case (state_q)
         FETCH: begin
            if (mem_listo) begin
               op_reg_d = op;
               state_d  = DECODE;
            end else if (limite) begin
               state_d = ERROR;
            end
         end
         DECODE: begin
            if (op_reg_q == OPC_R)
               state_d = EXEC_R;
            else if ((op_reg_q == OPC_LW) || (op_reg_q == OPC_SW))
               state_d = DIR_MEM;
            else if (op_reg_q == OPC_BEQ)
               state_d = SALTO;
            else
               state_d = FETCH;
         end
         EXEC_R:  state_d = WB_R;
         WB_R:    state_d = FETCH;
         DIR_MEM: begin
            if (op_reg_q == OPC_LW)
               state_d = LEE_MEM;
            else if (op_reg_q == OPC_SW)
               state_d = ESC_MEM;
            else
               state_d = FETCH;
         end
         LEE_MEM: begin
            if (mem_listo)
               state_d = WB_MEM;
            else if (limite)
               state_d = ERROR;
         end
         WB_MEM:  state_d = FETCH;
         ESC_MEM: begin
            if (mem_listo)
               state_d = FETCH;
            else if (limite)
               state_d = ERROR;
         end
         SALTO:   state_d = FETCH;
         ERROR:   state_d = ERROR;
         default: state_d = FETCH;
      endcase

      ctrl_d        = decodifica(state_d);
      op_invalida_d = (state_d == DECODE) &&
                      !(op_reg_d inside {OPC_R, OPC_LW, OPC_SW, OPC_BEQ});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         op_reg_q      <= '0;
         ctrl_q        <= decodifica(FETCH);
         op_invalida_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_reg_q      <= op_reg_d;
         ctrl_q        <= ctrl_d;
         op_invalida_q <= op_invalida_d;
      end
   end

`ifdef UC_CONTADOR_INSTR_EN
   logic [ANCHO_CONT-1:0] instr_cont_q, instr_cont_d;
   logic                  retira;

   always_comb begin
      retira       = (state_d == FETCH) &&
                     (state_q inside {WB_R, WB_MEM, ESC_MEM, SALTO});
      instr_cont_d = instr_cont_q;
      if (retira)
         instr_cont_d = instr_cont_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_cont_q <= '0;
      else
         instr_cont_q <= instr_cont_d;
   end

   assign instr_cont = instr_cont_q;
`else
   assign instr_cont = '0;
`endif

   assign mem_req     = ctrl_q.mem_req;
   assign MemRead     = ctrl_q.mem_read;
   assign MemToWrite  = ctrl_q.mem_write;
   assign IRWrite     = ctrl_q.ir_write;
   assign PCWrite     = ctrl_q.pc_write;
   assign PCWriteCond = ctrl_q.pc_write_cond;
   assign RegWrite    = ctrl_q.reg_write;
   assign MemToReg    = ctrl_q.mem_to_reg;
   assign AluOp       = ctrl_q.alu_op;
   assign estado      = state_q;
   assign op_invalida = op_invalida_q;
   assign error       = ctrl_q.error;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: instruction-level reference model
// expands each instruction into its expected per-cycle trace.
module tb_unidad_control_multiciclo;
   import uc_pkg::*;

   localparam int CW  = 2;
   localparam int MAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    op;
   logic          mem_listo;
   logic          mem_req, MemRead, MemToWrite, IRWrite, PCWrite, PCWriteCond;
   logic          RegWrite, MemToReg, op_invalida, error;
   logic [1:0]    AluOp;
   logic [3:0]    estado;
   logic [CW-1:0] instr_cont;

   int total = 0;
   int bad   = 0;
   int cont_esp = 0;

   unidad_control_multiciclo #(
      .ANCHO_OP   (6),
      .MAX_ESPERA (MAX),
      .ANCHO_CONT (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .mem_listo   (mem_listo),
      .mem_req     (mem_req),
      .MemRead     (MemRead),
      .MemToWrite  (MemToWrite),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .RegWrite    (RegWrite),
      .MemToReg    (MemToReg),
      .AluOp       (AluOp),
      .estado      (estado),
      .op_invalida (op_invalida),
      .error       (error),
      .instr_cont  (instr_cont)
   );

   always #5 clk = ~clk;

   logic [11:0] ctrl_obs;
   assign ctrl_obs = {mem_req, MemRead, MemToWrite, IRWrite, PCWrite, PCWriteCond,
                      RegWrite, MemToReg, AluOp, op_invalida, error};

   task automatic chequea(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Expected control word for a state, straight from the per-state output table.
   function automatic logic [11:0] exp_ctrl(input estado_t e, input logic inval);
      logic mr, rd, wr, ir, pc, pcc, rw, m2r, err;
      logic [1:0] alu;
      {mr, rd, wr, ir, pc, pcc, rw, m2r, err} = '0;
      alu = 2'b00;
      case (e)
         FETCH:   {mr, rd, ir, pc} = 4'b1111;
         EXEC_R:  alu = 2'b10;
         LEE_MEM: {mr, rd} = 2'b11;
         ESC_MEM: {mr, wr} = 2'b11;
         WB_R:    rw = 1'b1;
         WB_MEM:  {rw, m2r} = 2'b11;
         SALTO:   begin alu = 2'b01; pcc = 1'b1; end
         ERROR:   err = 1'b1;
         default: ;
      endcase
      return {mr, rd, wr, ir, pc, pcc, rw, m2r, alu, inval, err};
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   function automatic logic es_valido(input logic [5:0] o);
      return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100);
   endfunction

   // One clock cycle: drive inputs, check the state's outputs, advance.
   task automatic paso(input estado_t e, input logic listo, input logic [5:0] opv, input logic inval);
      mem_listo = listo;
      op        = opv;
      #1;
      chequea("estado", 32'(estado), 32'(e));
      chequea("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(e, inval)));
      chequea("instr_cont", 32'(instr_cont), 32'(cont_esp));
      @(posedge clk);
      #1;
   endtask

   task automatic retira_modelo();
`ifdef UC_CONTADOR_INSTR_EN
      cont_esp = (cont_esp + 1) % (1 << CW);
`endif
   endtask

   task automatic en_error();
      for (int k = 0; k < 4; k++)
         paso(ERROR, 1'($urandom), rnd_op(), 1'b0);
   endtask

   task automatic reinicia();
      rst_n = 1'b0;
      #1;
      cont_esp = 0;
      chequea("rst_estado", 32'(estado), 32'(FETCH));
      chequea("rst_cont", 32'(instr_cont), 32'd0);
      chequea("rst_flags", 32'({op_invalida, error, MemToWrite}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Memory access phase: wm stalled cycles, then ready (or timeout).
   task automatic acceso(input estado_t e, input int wm, output logic fallo);
      int n;
      n = (wm < MAX) ? wm : MAX;
      for (int i = 0; i < n; i++)
         paso(e, 1'b0, rnd_op(), 1'b0);
      fallo = (wm >= MAX);
      if (fallo)
         en_error();
      else
         paso(e, 1'b1, rnd_op(), 1'b0);
   endtask

   // Instruction-level model: wf fetch stalls, wm data-access stalls.
   task automatic instr(input logic [5:0] opc, input int wf, input int wm);
      logic fallo;
      int n;
      n = (wf < MAX) ? wf : MAX;
      for (int i = 0; i < n; i++)
         paso(FETCH, 1'b0, rnd_op(), 1'b0);
      if (wf >= MAX) begin
         en_error();
         return;
      end
      paso(FETCH, 1'b1, opc, 1'b0);
      paso(DECODE, 1'($urandom), rnd_op(), !es_valido(opc));
      case (opc)
         6'b000000: begin
            paso(EXEC_R, 1'($urandom), rnd_op(), 1'b0);
            paso(WB_R, 1'($urandom), rnd_op(), 1'b0);
            retira_modelo();
         end
         6'b100011: begin
            paso(DIR_MEM, 1'($urandom), rnd_op(), 1'b0);
            acceso(LEE_MEM, wm, fallo);
            if (!fallo) begin
               paso(WB_MEM, 1'($urandom), rnd_op(), 1'b0);
               retira_modelo();
            end
         end
         6'b101011: begin
            paso(DIR_MEM, 1'($urandom), rnd_op(), 1'b0);
            acceso(ESC_MEM, wm, fallo);
            if (!fallo)
               retira_modelo();
         end
         6'b000100: begin
            paso(SALTO, 1'($urandom), rnd_op(), 1'b0);
            retira_modelo();
         end
         default: ;
      endcase
   endtask

   function automatic int espera_rnd();
      return ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [5:0] opc;
      rst_n     = 1'b0;
      mem_listo = 1'b0;
      op        = '0;
      #3;
      chequea("rst_estado", 32'(estado), 32'(FETCH));
      chequea("rst_cont", 32'(instr_cont), 32'd0);
      chequea("rst_flags", 32'({op_invalida, error, MemToWrite}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Counter wrap: five branches read back 1,2,3,0,1 (or 0 without the counter).
      for (int i = 0; i < 5; i++)
         instr(6'b000100, 0, 0);
      instr(6'b000000, 0, 0);
      instr(6'b100011, 0, 3);
      instr(6'b111111, 0, 0);
      instr(6'b101011, 1, 2);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 4))
            0:       opc = 6'b000000;
            1:       opc = 6'b100011;
            2:       opc = 6'b101011;
            3:       opc = 6'b000100;
            default: opc = rnd_op();
         endcase
         instr(opc, espera_rnd(), espera_rnd());
      end

      // Reset in the middle of a store must drop the write strobe at once.
      paso(FETCH, 1'b1, 6'b101011, 1'b0);
      paso(DECODE, 1'b0, rnd_op(), 1'b0);
      paso(DIR_MEM, 1'b0, rnd_op(), 1'b0);
      paso(ESC_MEM, 1'b0, rnd_op(), 1'b0);
      mem_listo = 1'b0;
      #1;
      chequea("esc_wr_activo", 32'(MemToWrite), 32'd1);
      reinicia();
      instr(6'b000100, 0, 0);

      // Fetch timeout, then data-read timeout, then ready on the last allowed cycle.
      instr(6'b000000, MAX, 0);
      reinicia();
      instr(6'b100011, 0, MAX);
      reinicia();
      instr(6'b101011, 0, MAX);
      reinicia();
      instr(6'b000100, MAX - 1, 0);
      instr(6'b100011, 2, MAX - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/unidad_control_multiciclo.md
UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 Parameter ANCHO_OP, default 6: opcode width.
REQ-002 Parameter MAX_ESPERA, default 15: maximum memory wait cycles per access before timeout.
REQ-003 Parameter ANCHO_CONT, default 16: instruction counter width.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 op  input  ANCHO_OP  opcode from memory read data; sampled only at fetch completion.
REQ-007 mem_listo  input  1  memory ready; completes the access in progress.
REQ-008 mem_req, MemRead, MemToWrite  output  1 each  memory request, read strobe and write strobe.
REQ-009 IRWrite, PCWrite, PCWriteCond, RegWrite, MemToReg  output  1 each  datapath enables and writeback mux select.
REQ-010 AluOp  output  2  00 add, 01 sub, 10 R-type funct decode.
REQ-011 estado  output  4  current state code; op_invalida  output  1  one-cycle pulse; error  output  1  sticky timeout flag.
REQ-012 instr_cont  output  ANCHO_CONT  retired-instruction count.

Function
REQ-013 Moore FSM: every control output SHALL decode from the state register (plus registered opcode), with no combinational path from op or mem_listo.
REQ-014 States: FETCH, DECODE, EXEC_R, DIR_MEM, LEE_MEM, ESC_MEM, WB_R, WB_MEM, SALTO, ERROR.
REQ-015 FETCH: mem_req=1, MemRead=1; on mem_listo=1: IRWrite=1, PCWrite=1, AluOp=00, op latched into op_reg, next DECODE; otherwise stay.
REQ-016 DECODE: 000000 -> EXEC_R; 100011 or 101011 -> DIR_MEM; 000100 -> SALTO; any other code -> FETCH with op_invalida=1 for that cycle and no counter increment.
REQ-017 EXEC_R: AluOp=10 -> WB_R; WB_R: RegWrite=1, MemToReg=0 -> FETCH.
REQ-018 DIR_MEM: AluOp=00; op_reg 100011 -> LEE_MEM, 101011 -> ESC_MEM.
REQ-019 LEE_MEM: mem_req=1, MemRead=1; on mem_listo -> WB_MEM. WB_MEM: RegWrite=1, MemToReg=1 -> FETCH.
REQ-020 ESC_MEM: mem_req=1, MemToWrite=1; on mem_listo -> FETCH.
REQ-021 SALTO: AluOp=01, PCWriteCond=1 -> FETCH.
REQ-022 Zero-wait latency in cycles: beq 3, R-type 4, sw 4, lw 5.
REQ-023 Wait counter SHALL clear on entry to FETCH, LEE_MEM, ESC_MEM and increment each cycle mem_req=1 and mem_listo=0; when it reaches MAX_ESPERA with mem_listo still 0, next state ERROR.
REQ-024 mem_listo=1 in the same cycle the counter reaches MAX_ESPERA SHALL complete the access normally (ready wins).
REQ-025 ERROR: all enables and strobes 0, error=1, state held until reset.
REQ-026 mem_listo outside memory states SHALL be ignored.
REQ-027 Outputs not listed as asserted for a state SHALL be 0; AluOp defaults to 00.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state FETCH, op_reg 0, wait counter 0, error 0, instr_cont 0, op_invalida 0.
REQ-029 Reset asserted mid-access SHALL abandon the access; the first cycle after release starts a fresh FETCH with mem_req=1.

Configuration
REQ-030 Macro UC_CONTADOR_INSTR_EN defined: instr_cont increments by 1 (wrapping modulo 2^ANCHO_CONT) on every transition into FETCH from WB_R, WB_MEM, ESC_MEM or SALTO.
REQ-031 Macro undefined: instr_cont tied to 0 and no counter register is built.

Structure
REQ-032 Package uc_pkg SHALL hold the state encoding, opcode constants (R, LW, SW, BEQ) and AluOp encodings.
REQ-033 Sub-module contador_espera (clear, enable, limit reached) SHALL implement the wait/timeout counter.

Verification
REQ-034 Reset, then op=000000, mem_listo=1 constant -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 in cycle 4 only; instr_cont=1.
REQ-035 op=100011, mem_listo low 3 cycles in LEE_MEM -> WB_MEM reached after 8 cycles total with MemToReg=1, RegWrite=1.
REQ-036 op=111111 -> op_invalida pulses in DECODE cycle, back to FETCH, instr_cont unchanged.
REQ-037 FETCH with mem_listo=0 for MAX_ESPERA=15 cycles -> ERROR, error=1, all enables 0 until rst_n low; ready arriving on cycle 15 -> normal DECODE instead.
REQ-038 rst_n pulsed low during ESC_MEM -> MemToWrite drops immediately; FETCH after release; instr_cont=0.
REQ-039 ANCHO_CONT=2, five beq instructions with macro defined -> instr_cont reads 1,2,3,0,1; macro undefined -> always 0.
